// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises the serial line, validates the start bit,
// mid-bit samples data/parity/stop and presents each byte with error flags on a
// valid/ready handshake.
module uart_rx_deframer #(
  parameter int unsigned DIVISOR    = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 ref_clk,
  input  logic                 nreset,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(DIVISOR);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIVISOR - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic             ODD       = 1'(PARITY_ODD);
  localparam logic             HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  logic                 sync1, s_in;
  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 fe_q, fe_d, pe_q, pe_d, done_q, done_d;
  logic [DATA_BITS-1:0] rx_data_d;
  logic                 rx_valid_d, frame_err_d, parity_err_d, overrun_d, busy_d;

  // Two-flop synchroniser; the line idles high so the flops reset to 1.
  always_ff @(posedge ref_clk or negedge nreset) begin
    if (!nreset) begin
      sync1 <= 1'b1;
      s_in  <= 1'b1;
    end else begin
      sync1 <= serial_in;
      s_in  <= sync1;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge ref_clk or negedge nreset) begin
    if (!nreset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      done_q     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_cnt    <= bit_cnt_d;
      shift      <= shift_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      done_q     <= done_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      frame_err  <= frame_err_d;
      parity_err <= parity_err_d;
      overrun    <= overrun_d;
      busy       <= busy_d;
    end
  end

  // Next-state, sampling and output-register load logic.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt + CNT_W'(1);
    bit_cnt_d    = bit_cnt;
    shift_d      = shift;
    fe_d         = fe_q;
    pe_d         = pe_q;
    done_d       = 1'b0;
    rx_data_d    = rx_data;
    rx_valid_d   = rx_valid;
    frame_err_d  = frame_err;
    parity_err_d = parity_err;
    overrun_d    = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (!s_in) begin
          state_d   = S_START;
          bit_cnt_d = '0;
          pe_d      = 1'b0;
        end
      end
      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_d   = '0;
          state_d = s_in ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {s_in, shift[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt + BIT_W'(1);
          if (bit_cnt == DATA_LAST) state_d = HAS_PAR ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_d   = '0;
          pe_d    = ((^shift) ^ s_in) != ODD;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_d   = '0;
          fe_d    = ~s_in;
          done_d  = 1'b1;
          state_d = s_in ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (s_in) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A finished frame loads only if the register is free or being drained now.
    if (done_q) begin
      if (!rx_valid || rx_ready) begin
        rx_data_d    = shift;
        frame_err_d  = fe_q;
        parity_err_d = pe_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: an 8N1 instance and an 8E1 instance.
module tb_uart_rx_deframer;

  localparam int unsigned D = 16;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       ser_a = 1'b1, ser_b = 1'b1;
  logic       rdy_a = 1'b1, rdy_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       val_a, fe_a, pe_a, ovr_a, busy_a;
  logic       val_b, fe_b, pe_b, ovr_b, busy_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_rx_deframer #(.DIVISOR(D), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .ref_clk(clk), .nreset(nreset), .serial_in(ser_a), .rx_data(data_a), .rx_valid(val_a),
    .rx_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ovr_a), .busy(busy_a));

  uart_rx_deframer #(.DIVISOR(D), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .ref_clk(clk), .nreset(nreset), .serial_in(ser_b), .rx_data(data_b), .rx_valid(val_b),
    .rx_ready(rdy_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ovr_b), .busy(busy_b));

  // Handshake monitors: record every accepted byte and count overrun cycles.
  int         acc_a = 0, acc_b = 0, ovr_cnt_a = 0, ovr_cnt_b = 0;
  logic [7:0] last_a = '0, last_b = '0;
  logic       lfe_a = 1'b0, lpe_a = 1'b0, lfe_b = 1'b0, lpe_b = 1'b0;

  always @(posedge clk) begin
    if (val_a && rdy_a) begin
      acc_a++;
      last_a = data_a;
      lfe_a  = fe_a;
      lpe_a  = pe_a;
    end
    if (val_b && rdy_b) begin
      acc_b++;
      last_b = data_b;
      lfe_b  = fe_b;
      lpe_b  = pe_b;
    end
    if (ovr_a) ovr_cnt_a++;
    if (ovr_b) ovr_cnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) ser_b = v;
    else     ser_a = v;
    repeat (D) @(negedge clk);
  endtask

  // Start bit, data LSB first, optional parity, stop; line left at the stop value.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                            input logic par, input logic stop);
    drive(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive(sel, d[i]);
    if (par_en) drive(sel, par);
    drive(sel, stop);
  endtask

  int  n, a0, o0;
  bit  seen;

  initial begin
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_valid_a", 32'(val_a), 32'h0);
    check("rst_data_a", 32'(data_a), 32'h0);
    check("rst_flags_a", {28'h0, fe_a, pe_a, ovr_a, busy_a}, 32'h0);
    check("rst_valid_b", 32'(val_b), 32'h0);
    check("rst_flags_b", {28'h0, fe_b, pe_b, ovr_b, busy_b}, 32'h0);
    nreset = 1'b1;
    repeat (4) @(negedge clk);

    // T1: 8N1 0x55, latency 2 + 8 + 9*16 + 1 = 155
    a0 = acc_a;
    fork
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
      begin
        n = 0;
        seen = 1'b0;
        @(posedge clk);
        while (!seen && n < 400) begin
          @(posedge clk);
          n++;
          #1;
          if (val_a) begin
            seen = 1'b1;
            check("t1_latency", 32'(n), 32'd155);
            check("t1_data", 32'(data_a), 32'h55);
            check("t1_fe", 32'(fe_a), 32'h0);
            check("t1_pe", 32'(pe_a), 32'h0);
            @(posedge clk);
            #1;
            check("t1_valid_drop", 32'(val_a), 32'h0);
          end
        end
        if (!seen) check("t1_timeout", 32'(seen), 32'h1);
      end
    join
    repeat (D) @(negedge clk);
    check("t1_accepts", 32'(acc_a - a0), 32'd1);

    // T2: 4-cycle glitch is rejected
    a0 = acc_a;
    ser_a = 1'b0;
    repeat (4) @(negedge clk);
    ser_a = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (!busy_a) seen = 1'b1;
    end
    check("t2_busy_idle", 32'(seen), 32'h1);
    repeat (3 * D) @(negedge clk);
    check("t2_no_frame", 32'(acc_a - a0), 32'd0);

    // T3: 0xA3 with bad stop then a 40-bit-time break, then 0x3C
    a0 = acc_a;
    send_frame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b0);
    repeat (40 * D) @(negedge clk);
    check("t3_break_busy", 32'(busy_a), 32'h1);
    check("t3_one_frame", 32'(acc_a - a0), 32'd1);
    check("t3_data", 32'(last_a), 32'hA3);
    check("t3_fe", 32'(lfe_a), 32'h1);
    ser_a = 1'b1;
    repeat (2 * D) @(negedge clk);
    check("t3_still_one", 32'(acc_a - a0), 32'd1);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (D) @(negedge clk);
    check("t3_second", 32'(acc_a - a0), 32'd2);
    check("t3_data2", 32'(last_a), 32'h3C);
    check("t3_fe2", 32'(lfe_a), 32'h0);

    // T4: back-to-back 0x11, 0x22 with rx_ready low
    rdy_a = 1'b0;
    a0 = acc_a;
    o0 = ovr_cnt_a;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    repeat (D) @(negedge clk);
    check("t4_valid", 32'(val_a), 32'h1);
    check("t4_data", 32'(data_a), 32'h11);
    check("t4_overrun", 32'(ovr_cnt_a - o0), 32'd1);
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    check("t4_valid_clr", 32'(val_a), 32'h0);
    check("t4_accept", 32'(acc_a - a0), 32'd1);
    check("t4_acc_data", 32'(last_a), 32'h11);

    // T5: even parity, 0x07 has odd weight so parity bit 1 is correct
    a0 = acc_b;
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    repeat (D) @(negedge clk);
    check("t5_frame", 32'(acc_b - a0), 32'd1);
    check("t5_data", 32'(last_b), 32'h07);
    check("t5_pe_bad", 32'(lpe_b), 32'h1);
    check("t5_fe", 32'(lfe_b), 32'h0);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    repeat (D) @(negedge clk);
    check("t5_frame2", 32'(acc_b - a0), 32'd2);
    check("t5_pe_ok", 32'(lpe_b), 32'h0);
    check("t5_ovr", 32'(ovr_cnt_b), 32'd0);

    // T6: reset in the middle of DATA with a byte held
    send_frame(1'b0, 8'h99, 1'b0, 1'b0, 1'b1);
    repeat (D) @(negedge clk);
    check("t6_held", 32'(val_a), 32'h1);
    a0 = acc_a;
    fork
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
      begin
        repeat (4 * D) @(negedge clk);
        nreset = 1'b0;
        #1;
        check("t6_rst_valid", 32'(val_a), 32'h0);
        check("t6_rst_data", 32'(data_a), 32'h0);
        check("t6_rst_flags", {28'h0, fe_a, pe_a, ovr_a, busy_a}, 32'h0);
      end
    join
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    rdy_a = 1'b1;
    repeat (D) @(negedge clk);
    send_frame(1'b0, 8'hF0, 1'b0, 1'b0, 1'b1);
    repeat (D) @(negedge clk);
    check("t6_frames", 32'(acc_a - a0), 32'd1);
    check("t6_data", 32'(last_a), 32'hF0);
    check("t6_fe", 32'(lfe_a), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
